// File: rtl/div_unit_pkg.sv
// Shared constants for the radix-2 restoring divider: FSM encodings and counter width.
package div_unit_pkg;

    typedef logic [1:0] div_state_t;

    localparam div_state_t DIV_IDLE = 2'b00;
    localparam div_state_t DIV_BUSY = 2'b01;
    localparam div_state_t DIV_DONE = 2'b10;

    localparam int DIV_CNT_W = 5;

endpackage

// File: rtl/div_unit_step.sv
// One combinational restoring-division step: shift {rem, q} left, trial-subtract dvs.
module div_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] q_nxt
);

    logic [WIDTH:0] trial;

    // rem < dvs holds between steps, so one extra bit is enough for the sign of the trial.
    assign trial   = {rem, q[WIDTH-1]} - {1'b0, dvs};
    assign rem_nxt = trial[WIDTH] ? {rem[WIDTH-2:0], q[WIDTH-1]} : trial[WIDTH-1:0];
    assign q_nxt   = {q[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for the EX stage; stalls the pipeline and returns {remainder, quotient}.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic               annul_i,
    input  logic [WIDTH-1:0]   dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
    output logic               stall_o,
    output logic               result_valid_o,
    output logic [2*WIDTH-1:0] result_o
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;

    logic             accept;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] rem_fix;
    logic             last_step;

    assign accept  = (state != DIV_BUSY) && start_i && !annul_i;
    assign dvd_neg = signed_i & dividend_i[WIDTH-1];
    assign dvs_neg = signed_i & divisor_i[WIDTH-1];

    // -2^(WIDTH-1) negates to itself, which is exactly its unsigned magnitude.
    assign dvd_mag = dvd_neg ? -dividend_i : dividend_i;
    assign dvs_mag = dvs_neg ? -divisor_i  : divisor_i;

    div_unit_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .q       (q),
        .dvs     (dvs),
        .rem_nxt (rem_nxt),
        .q_nxt   (q_nxt)
    );

    assign last_step = (cnt == CNT_W'(WIDTH - 1));
    assign q_fix     = neg_q ? -q_nxt   : q_nxt;
    assign rem_fix   = neg_r ? -rem_nxt : rem_nxt;

    // Combinational so the requesting instruction is held from its first EX cycle.
    assign stall_o        = accept || ((state == DIV_BUSY) && !annul_i);
    assign result_valid_o = (state == DIV_DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= DIV_IDLE;
            cnt      <= '0;
            rem      <= '0;
            q        <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                DIV_BUSY: begin
                    if (annul_i) begin
                        state <= DIV_IDLE;
                    end else begin
                        rem <= rem_nxt;
                        q   <= q_nxt;
                        cnt <= cnt + CNT_W'(1);
                        if (last_step) begin
                            state    <= DIV_DONE;
                            result_o <= {rem_fix, q_fix};
                        end
                    end
                end
                default: begin
                    if (!accept) begin
                        state <= DIV_IDLE;
                    end else if (divisor_i == '0) begin
                        state    <= DIV_DONE;
                        result_o <= {dividend_i, {WIDTH{1'b1}}};
                    end else begin
                        state <= DIV_BUSY;
                        q     <= dvd_mag;
                        dvs   <= dvs_mag;
                        rem   <= '0;
                        cnt   <= '0;
                        neg_q <= dvd_neg ^ dvs_neg;
                        neg_r <= dvd_neg;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed divides push expected {hi, lo} and arrival cycle; a monitor checks.
module tb_div_unit;

    localparam int WIDTH = 32;

    typedef struct {
        logic [2*WIDTH-1:0] data;
        int                 cyc;
    } exp_t;

    logic               clk;
    logic               resetn;
    logic               start_i;
    logic               signed_i;
    logic               annul_i;
    logic [WIDTH-1:0]   dividend_i;
    logic [WIDTH-1:0]   divisor_i;
    logic               stall_o;
    logic               result_valid_o;
    logic [2*WIDTH-1:0] result_o;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t sb[$];
    exp_t mon_e;

    div_unit #(.WIDTH(WIDTH)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .start_i        (start_i),
        .signed_i       (signed_i),
        .annul_i        (annul_i),
        .dividend_i     (dividend_i),
        .divisor_i      (divisor_i),
        .stall_o        (stall_o),
        .result_valid_o (result_valid_o),
        .result_o       (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [2*WIDTH-1:0] act, input logic [2*WIDTH-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every result strobe must match the oldest outstanding expectation, on the expected cycle.
    always @(negedge clk) begin
        if (resetn === 1'b1 && result_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got %h with no request outstanding (cycle %0d)", result_o, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("result", result_o, mon_e.data);
                check("latency_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sgn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start_i    = 1'b1;
        signed_i   = sgn;
        dividend_i = a;
        divisor_i  = b;
    endtask

    task automatic issue(input logic sgn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] hi, input logic [WIDTH-1:0] lo, input int lat);
        exp_t e;
        e.data = {hi, lo};
        e.cyc  = cyc + lat;
        sb.push_back(e);
        drive(sgn, a, b);
    endtask

    // Start held through the busy cycles (ignored there), dropped in the result cycle.
    task automatic run_div(input logic sgn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] hi, input logic [WIDTH-1:0] lo, input int lat);
        next_cycle();
        issue(sgn, a, b, hi, lo, lat);
        repeat (lat) next_cycle();
        start_i = 1'b0;
        @(negedge clk);
        check("stall_in_done", 64'(stall_o), 64'd0);
        next_cycle();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 80) begin
            next_cycle();
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d outstanding results expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        resetn     = 1'b0;
        start_i    = 1'b0;
        signed_i   = 1'b0;
        annul_i    = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        #12;
        check("reset_stall", 64'(stall_o), 64'd0);
        check("reset_valid", 64'(result_valid_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        next_cycle();
        resetn = 1'b1;
        next_cycle();

        // 1: DIVU 100 / 7, stall high for cycles 0..32, low in the result cycle.
        next_cycle();
        issue(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        for (int i = 0; i <= 32; i++) begin
            @(negedge clk);
            check($sformatf("t1_stall_c%0d", i), 64'(stall_o), 64'd1);
            next_cycle();
        end
        start_i = 1'b0;
        @(negedge clk);
        check("t1_stall_c33", 64'(stall_o), 64'd0);
        next_cycle();
        drain();

        // 2: DIV -7 / 2 -> q = -3, r = -1.
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        // 3: DIV -2^31 / -1 -> overflow wraps, no trap.
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
        // Extra signed mixes: 7 / -2 -> q = -3, r = 1; -2^31 / 3 unsigned.
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33);
        run_div(1'b0, 32'h8000_0000, 32'd3, 32'd2, 32'h2AAA_AAAA, 33);
        drain();

        // 4: DIVU 5 / 0 -> result next cycle, stall only in the request cycle.
        next_cycle();
        issue(1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1);
        @(negedge clk);
        check("t4_stall_c0", 64'(stall_o), 64'd1);
        next_cycle();
        start_i = 1'b0;
        @(negedge clk);
        check("t4_stall_c1", 64'(stall_o), 64'd0);
        next_cycle();
        drain();

        // 5: DIV 1000 / 3 annulled in cycle 10; no result, old result_o retained.
        next_cycle();
        drive(1'b1, 32'd1000, 32'd3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("t5_stall_c%0d", i), 64'(stall_o), 64'd1);
            next_cycle();
        end
        start_i = 1'b0;
        annul_i = 1'b1;
        @(negedge clk);
        check("t5_stall_c10", 64'(stall_o), 64'd0);
        next_cycle();
        annul_i = 1'b0;
        @(negedge clk);
        check("t5_stall_c11", 64'(stall_o), 64'd0);
        check("t5_valid_c11", 64'(result_valid_o), 64'd0);
        check("t5_result_kept", result_o, {32'd5, 32'hFFFF_FFFF});
        run_div(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 33);
        drain();

        // 6: reset in mid-divide, then DIVU 9 / 3 with a back-to-back DIVU 100 / 7 in its done cycle.
        next_cycle();
        drive(1'b0, 32'd100, 32'd7);
        repeat (15) next_cycle();
        resetn  = 1'b0;
        start_i = 1'b0;
        #1;
        check("t6_reset_valid", 64'(result_valid_o), 64'd0);
        check("t6_reset_stall", 64'(stall_o), 64'd0);
        check("t6_reset_result", result_o, 64'd0);
        next_cycle();
        next_cycle();
        resetn = 1'b1;
        next_cycle();
        issue(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 33);
        repeat (33) next_cycle();
        issue(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        @(negedge clk);
        check("t6_b2b_stall", 64'(stall_o), 64'd1);
        repeat (33) next_cycle();
        start_i = 1'b0;
        next_cycle();
        drain();

        repeat (3) next_cycle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
